// File: rtl/ifetch_break_ctrl.sv
`default_nettype none
// ============================================================================
// ifetch_break_ctrl : fetch PC sequencer with stall/redirect and BREAK halt
// Revision 1.0
// ============================================================================
module ifetch_break_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              brk_valid,
  output logic [19:0]       brk_code,
  output logic [ADDR_W-1:0] brk_pc,
  input  logic              brk_ack,
  output logic              halted,
  output logic [7:0]        brk_count
);

  typedef enum logic [0:0] {
    RUN = 1'b0,
    BRK = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                w_is_brk;

  assign rom_addr = r_pc;
  assign w_is_brk = (rom_instr[31:26] == 6'h00) && (rom_instr[5:0] == 6'h0d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      brk_valid <= 1'b0;
      brk_code  <= '0;
      brk_pc    <= '0;
      halted    <= 1'b0;
      brk_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (redirect_valid) begin
            // Squashed word is never inspected, so a BREAK in a branch shadow is ignored.
            r_pc     <= redirect_addr;
            if_valid <= 1'b0;
          end else if (!stall) begin
            r_pc <= r_pc + 1'b1;
            if (w_is_brk) begin
              if_valid  <= 1'b0;
              brk_valid <= 1'b1;
              brk_code  <= rom_instr[25:6];
              brk_pc    <= r_pc;
              halted    <= 1'b1;
              r_state   <= BRK;
              if (brk_count != 8'hff) brk_count <= brk_count + 8'd1;
            end else begin
              if_valid <= 1'b1;
              if_instr <= rom_instr;
              if_pc    <= r_pc;
            end
          end
        end
        BRK: begin
          if_valid <= 1'b0;
          if (redirect_valid) r_pc <= redirect_addr;
          if (brk_ack) begin
            brk_valid <= 1'b0;
            halted    <= 1'b0;
            r_state   <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_break_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ifetch_break_ctrl : scoreboard bench for the fetch/BREAK sequencer
// Revision 1.0
// ============================================================================
module tb_ifetch_break_ctrl;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              stall, redirect_valid, brk_ack;
  logic [ADDR_W-1:0] redirect_addr;
  logic              if_valid, brk_valid, halted;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc, brk_pc;
  logic [19:0]       brk_code;
  logic [7:0]        brk_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;

  always #5 clk = ~clk;

  ifetch_break_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .brk_valid(brk_valid), .brk_code(brk_code), .brk_pc(brk_pc),
    .brk_ack(brk_ack), .halted(halted), .brk_count(brk_count)
  );

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      5'h00: rom_word = 32'h24010001;
      5'h01: rom_word = 32'h24020002;
      5'h02: rom_word = 32'h24030003;
      5'h03: rom_word = 32'h000000cd;  // BREAK 3
      5'h04: rom_word = 32'h24040004;
      5'h05: rom_word = 32'h24050005;
      5'h06: rom_word = 32'h0000014d;  // BREAK 5
      5'h07: rom_word = 32'h24060006;
      5'h08: rom_word = 32'h24070007;
      5'h09: rom_word = 32'h000001cd;  // BREAK 7
      5'h0a: rom_word = 32'h24080008;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  assign rom_instr = rom_word(rom_addr);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              v;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] ipc;
    logic              bv;
    logic [19:0]       code;
    logic [ADDR_W-1:0] bpc;
    logic              h;
    logic [7:0]        cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  logic m_in_brk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m = '0;
    m_in_brk = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [ADDR_W-1:0] ra,
                            input logic ack);
    logic [31:0] w;
    w = rom_word(m.pc);
    if (!m_in_brk) begin
      if (rv) begin
        m.pc = ra;
        m.v  = 1'b0;
      end else if (!st) begin
        if (w[31:26] == 6'h00 && w[5:0] == 6'h0d) begin
          m.v = 1'b0; m.bv = 1'b1; m.code = w[25:6]; m.bpc = m.pc; m.h = 1'b1;
          if (m.cnt != 8'hff) m.cnt = m.cnt + 8'd1;
          m_in_brk = 1'b1;
        end else begin
          m.v = 1'b1; m.instr = w; m.ipc = m.pc;
        end
        m.pc = m.pc + 5'd1;
      end
    end else begin
      m.v = 1'b0;
      if (rv) m.pc = ra;
      if (ack) begin
        m.bv = 1'b0; m.h = 1'b0; m_in_brk = 1'b0;
      end
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    check("rom_addr", 32'(rom_addr), 32'(e.pc));
    check("if_valid", 32'(if_valid), 32'(e.v));
    check("if_instr", if_instr, e.instr);
    check("if_pc", 32'(if_pc), 32'(e.ipc));
    check("brk_valid", 32'(brk_valid), 32'(e.bv));
    check("brk_code", 32'(brk_code), 32'(e.code));
    check("brk_pc", 32'(brk_pc), 32'(e.bpc));
    check("halted", 32'(halted), 32'(e.h));
    check("brk_count", 32'(brk_count), 32'(e.cnt));
  endtask

  // Drive one cycle of inputs away from the edge, predict, then compare after the edge.
  task automatic cycle(input logic st, input logic rv, input logic [ADDR_W-1:0] ra,
                       input logic ack);
    stall = st; redirect_valid = rv; redirect_addr = ra; brk_ack = ack;
    model_step(st, rv, ra, ack);
    sbq.push_back(m);
    @(posedge clk);
    #1;
    compare_front();
    if (if_valid === 1'b1) n_deliv++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_instr"}, if_instr, 32'd0);
    check({tag, "_if_pc"}, 32'(if_pc), 32'd0);
    check({tag, "_brk_valid"}, 32'(brk_valid), 32'd0);
    check({tag, "_brk_code"}, 32'(brk_code), 32'd0);
    check({tag, "_brk_pc"}, 32'(brk_pc), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_brk_count"}, 32'(brk_count), 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; brk_ack = 1'b0;
    model_reset();
    #12 check_reset_outputs("por");
    rst_n = 1'b1;

    // Straight fetch
    cycle(0, 0, 0, 0); check("f0_instr", if_instr, 32'h24010001); check("f0_pc", 32'(if_pc), 32'd0);
    cycle(0, 0, 0, 0); check("f1_instr", if_instr, 32'h24020002); check("f1_pc", 32'(if_pc), 32'd1);
    cycle(0, 0, 0, 0); check("f2_instr", if_instr, 32'h24030003); check("f2_pc", 32'(if_pc), 32'd2);

    // BREAK at 3, long hold (stall toggled to show it is ignored)
    cycle(0, 0, 0, 0);
    check("b3_valid", 32'(brk_valid), 32'd1); check("b3_code", 32'(brk_code), 32'd3);
    check("b3_pc", 32'(brk_pc), 32'd3);       check("b3_halted", 32'(halted), 32'd1);
    check("b3_count", 32'(brk_count), 32'd1); check("b3_ifv", 32'(if_valid), 32'd0);
    check("b3_addr", 32'(rom_addr), 32'd4);
    for (int i = 0; i < 5; i++) begin
      cycle(i[0], 0, 0, 0);
      check("hold_halted", 32'(halted), 32'd1); check("hold_code", 32'(brk_code), 32'd3);
      check("hold_ifv", 32'(if_valid), 32'd0);
    end
    cycle(0, 0, 0, 1);
    check("ack_halted", 32'(halted), 32'd0); check("ack_bv", 32'(brk_valid), 32'd0);
    check("ack_code_kept", 32'(brk_code), 32'd3);
    cycle(0, 0, 0, 0); check("resume_instr", if_instr, 32'h24040004);

    // Rest of the program, ack 3 cycles after each BREAK
    run(1);            check("f5_instr", if_instr, 32'h24050005);
    run(1);            check("b6_code", 32'(brk_code), 32'd5); check("b6_pc", 32'(brk_pc), 32'd6);
    run(2); cycle(0, 0, 0, 1);
    run(1);            check("f7_instr", if_instr, 32'h24060006);
    run(1);            check("f8_instr", if_instr, 32'h24070007);
    run(1);            check("b9_code", 32'(brk_code), 32'd7); check("b9_pc", 32'(brk_pc), 32'd9);
    run(2); cycle(0, 0, 0, 1);
    run(1);            check("fa_instr", if_instr, 32'h24080008);
    check("prog_count", 32'(brk_count), 32'd3);
    check("prog_deliv", 32'(n_deliv), 32'd8);

    // Stall hold
    async_reset("rst1");
    run(2); check("st_pre", if_instr, 32'h24020002);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      check("st_instr", if_instr, 32'h24020002); check("st_addr", 32'(rom_addr), 32'd2);
      check("st_ifv", 32'(if_valid), 32'd1);
    end
    run(1); check("st_post", if_instr, 32'h24030003);

    // Redirect with stall at pc=4, redirect inside BRK
    run(1); cycle(0, 0, 0, 1); check("rd_pc4", 32'(rom_addr), 32'd4);
    cycle(1, 1, 5'h07, 0);
    check("rd_ifv", 32'(if_valid), 32'd0); check("rd_addr", 32'(rom_addr), 32'd7);
    run(1); check("rd_target", if_instr, 32'h24060006);
    run(2); check("rd_brk", 32'(halted), 32'd1);
    cycle(0, 1, 5'h0a, 0); check("rdb_addr", 32'(rom_addr), 32'h0a); check("rdb_halt", 32'(halted), 32'd1);
    cycle(0, 0, 0, 1);
    run(1); check("rdb_target", if_instr, 32'h24080008);

    // PC wrap; ack in RUN has no effect
    cycle(0, 1, 5'h1f, 1);
    run(1); check("wrap_ipc", 32'(if_pc), 32'h1f); check("wrap_addr", 32'(rom_addr), 32'd0);

    // Saturate the BREAK counter
    for (int i = 0; i < 260; i++) begin
      cycle(0, 1, 5'h03, 0);
      run(1);
      cycle(0, 0, 0, 1);
    end
    check("sat_count", 32'(brk_count), 32'd255);

    // Reset while halted
    cycle(0, 1, 5'h03, 0);
    run(1); check("pre_rst_halt", 32'(halted), 32'd1);
    async_reset("rst_brk");
    run(1); check("post_rst_instr", if_instr, 32'h24010001); check("post_rst_pc", 32'(if_pc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
